// File: rtl/rv32i_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_dmem_responder_if
// Purpose  : Request/response handshake bundle between core MEM stage and dmem.
// Revision : 1.0
// ============================================================================
interface rv32i_dmem_responder_if #(
   parameter int WIDTH = 32
);
   logic             i_req_valid;
   logic             o_req_ready;
   logic             i_req_we;
   logic [WIDTH-1:0] i_req_addr;
   logic [WIDTH-1:0] i_req_wdata;
   logic [2:0]       i_req_funct3;
   logic             o_rsp_valid;
   logic             i_rsp_ready;
   logic [WIDTH-1:0] o_rsp_rdata;
   logic             o_rsp_err;

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/rv32i_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_dmem_responder
// Purpose  : RV32I data memory with byte-lane stores, extended loads and a
//            fixed access latency. Optional macro: DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module rv32i_dmem_responder #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  wire logic              clk,
   input  wire logic              rst,
   rv32i_dmem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int NB = WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             accept, access, mem_we;
   logic             we_q;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic [2:0]       f3_q;
   logic             acc_we;
   logic [WIDTH-1:0] acc_addr, acc_wdata;
   logic [2:0]       acc_f3;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] word, ld_data, st_data;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [NB-1:0]    be;
   logic             illegal, misalign, err_w;
   logic [WIDTH-1:0] rdata_q;
   logic             err_q;
   logic [WIDTH-1:0] mem [DEPTH_WORDS];
   logic             unused_addr_hi;

   assign bus.o_req_ready = (state == IDLE) && !rst;
   assign bus.o_rsp_valid = (state == RESP);
   assign bus.o_rsp_rdata = rdata_q;
   assign bus.o_rsp_err   = err_q;
   assign accept          = bus.i_req_valid && bus.o_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      access    = 1'b0;
      case (state)
         IDLE: if (accept) begin
            if (LATENCY == 1) begin
               state_nxt = RESP;
               access    = 1'b1;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: if (cnt == '0) begin
            state_nxt = RESP;
            access    = 1'b1;
         end
         RESP: if (bus.i_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With LATENCY==1 the access happens on the accept edge, so use live inputs.
   assign acc_we    = (state == IDLE) ? bus.i_req_we     : we_q;
   assign acc_addr  = (state == IDLE) ? bus.i_req_addr   : addr_q;
   assign acc_wdata = (state == IDLE) ? bus.i_req_wdata  : wdata_q;
   assign acc_f3    = (state == IDLE) ? bus.i_req_funct3 : f3_q;
   assign unused_addr_hi = &{1'b0, acc_addr[WIDTH-1:AW+2]};

   always_comb begin
      idx     = acc_addr[AW+1:2];
      word    = mem[idx];
      illegal = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111) ||
                (acc_we && acc_f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                 ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      err_w   = illegal || misalign;

      ld_byte = 8'(word >> {acc_addr[1:0], 3'b000});
      ld_half = acc_addr[1] ? word[31:16] : word[15:0];
      case (acc_f3)
         3'b000:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
         3'b010:  ld_data = word;
         3'b100:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
         default: ld_data = '0;
      endcase

      be      = '0;
      st_data = acc_wdata;
      case (acc_f3[1:0])
         2'b00: begin
            be      = NB'(1) << acc_addr[1:0];
            st_data = {NB{acc_wdata[7:0]}};
         end
         2'b01: begin
            be      = acc_addr[1] ? NB'(4'b1100) : NB'(4'b0011);
            st_data = {(NB/2){acc_wdata[15:0]}};
         end
         2'b10:   be = '1;
         default: be = '0;
      endcase
   end

   assign mem_we = access && acc_we && !err_w && !rst;

   // RAM is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= CW'(LATENCY - 1);
            we_q    <= bus.i_req_we;
            addr_q  <= bus.i_req_addr;
            wdata_q <= bus.i_req_wdata;
            f3_q    <= bus.i_req_funct3;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            rdata_q <= (acc_we || err_w) ? '0 : ld_data;
            err_q   <= err_w;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_dmem_responder
// Purpose  : Directed scoreboard bench for rv32i_dmem_responder.
// Revision : 1.0
// ============================================================================
module tb_rv32i_dmem_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 1024;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   rv32i_dmem_responder_if #(.WIDTH(32)) bus ();

   rv32i_dmem_responder #(
      .WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] er, input logic ee, input int hold);
      int   w;
      int   lat;
      exp_t e;
      sb.push_back('{tag, er, ee});
      @(negedge clk);
      bus.i_req_valid  = 1'b1;
      bus.i_req_we     = we;
      bus.i_req_addr   = addr;
      bus.i_req_wdata  = wdata;
      bus.i_req_funct3 = f3;
      bus.i_rsp_ready  = (hold == 0);
      w = 0;
      while (!bus.o_req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.o_req_ready) begin
         check({tag, "_accept"}, 32'(bus.o_req_ready), 32'd1);
         bus.i_req_valid = 1'b0;
         void'(sb.pop_front());
         return;
      end
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      lat = 0;
      while (!bus.o_rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(LAT));
      e = sb.pop_front();
      if (!bus.o_rsp_valid) return;
      check({e.tag, "_rdata"}, bus.o_rsp_rdata, e.rdata);
      check({e.tag, "_err"}, 32'(bus.o_rsp_err), 32'(e.err));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, 32'(bus.o_rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.o_rsp_rdata, e.rdata);
            check({tag, "_hold_reqrdy"}, 32'(bus.o_req_ready), 32'd0);
            @(negedge clk);
         end
         bus.i_rsp_ready = 1'b1;
         check({tag, "_hs_reqrdy"}, 32'(bus.o_req_ready), 32'd0);
         @(negedge clk);
         check({tag, "_post_valid"}, 32'(bus.o_rsp_valid), 32'd0);
         check({tag, "_post_reqrdy"}, 32'(bus.o_req_ready), 32'd1);
      end
   endtask

   logic [31:0] w100;
   logic        trap;

   initial begin
      bus.i_req_valid  = 1'b0;
      bus.i_req_we     = 1'b0;
      bus.i_req_addr   = '0;
      bus.i_req_wdata  = '0;
      bus.i_req_funct3 = '0;
      bus.i_rsp_ready  = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      trap = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_reqrdy", 32'(bus.o_req_ready), 32'd0);
      check("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
      check("rst_rdata", bus.o_rsp_rdata, 32'd0);
      check("rst_err", 32'(bus.o_rsp_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_reqrdy", 32'(bus.o_req_ready), 32'd1);

      xact("sw100", 1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
      xact("lw100", 0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0);
      xact("sb101", 1, 32'h101, 32'h0000007F, 3'b000, 32'h0, 0, 0);
      xact("lb101", 0, 32'h101, 32'h0, 3'b000, 32'h0000007F, 0, 0);
      xact("lb103", 0, 32'h103, 32'h0, 3'b000, 32'hFFFFFFDE, 0, 0);
      xact("lbu103", 0, 32'h103, 32'h0, 3'b100, 32'h000000DE, 0, 0);
      xact("lhu102", 0, 32'h102, 32'h0, 3'b101, 32'h0000DEAD, 0, 0);
      xact("lh102", 0, 32'h102, 32'h0, 3'b001, 32'hFFFFDEAD, 0, 0);
      xact("lw100b", 0, 32'h100, 32'h0, 3'b010, 32'hDEAD7FEF, 0, 0);
      xact("sh102", 1, 32'h102, 32'hFFFF1234, 3'b001, 32'h0, 0, 0);
      xact("lw100c", 0, 32'h100, 32'h0, 3'b010, 32'h12347FEF, 0, 0);

      xact("bp_lw", 0, 32'h100, 32'h0, 3'b010, 32'h12347FEF, 0, 5);

      xact("lw102", 0, 32'h102, 32'h0, 3'b010, trap ? 32'h0 : 32'h12347FEF, trap, 0);
      xact("sw102", 1, 32'h102, 32'hCAFEF00D, 3'b010, 32'h0, trap, 0);
      w100 = trap ? 32'h12347FEF : 32'hCAFEF00D;
      xact("lw100d", 0, 32'h100, 32'h0, 3'b010, w100, 0, 0);

      xact("ld_f3_011", 0, 32'h100, 32'h0, 3'b011, 32'h0, 1, 0);
      xact("st_f3_100", 1, 32'h100, 32'h00000000, 3'b100, 32'h0, 1, 0);
      xact("lw100e", 0, 32'h100, 32'h0, 3'b010, w100, 0, 0);

      xact("sw200", 1, 32'h200, 32'h11223344, 3'b010, 32'h0, 0, 0);
      @(negedge clk);
      bus.i_req_valid  = 1'b1;
      bus.i_req_we     = 1'b1;
      bus.i_req_addr   = 32'h200;
      bus.i_req_wdata  = 32'h00000055;
      bus.i_req_funct3 = 3'b010;
      check("rstw_reqrdy", 32'(bus.o_req_ready), 32'd1);
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rstw_reqrdy_in_rst", 32'(bus.o_req_ready), 32'd0);
      check("rstw_valid_in_rst", 32'(bus.o_rsp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rstw_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
      end
      xact("lw200", 0, 32'h200, 32'h0, 3'b010, 32'h11223344, 0, 0);
      xact("lw_alias", 0, DEPTH * 4 + 32'h200, 32'h0, 3'b010, 32'h11223344, 0, 0);
      xact("sb_alias", 1, DEPTH * 4 + 32'h203, 32'h000000AA, 3'b000, 32'h0, 0, 0);
      xact("lw200b", 0, 32'h200, 32'h0, 3'b010, 32'hAA223344, 0, 0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
